// File: rtl/cos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cos_pkg
//  Description : Shared widths, fixed-point angle constants, controller state
//                encoding and the single shift-subtract step used by the
//                modulo-2*pi reducer of the cosine range-reduction front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package cos_pkg;

    localparam int ANGLE_W     = 24;   // angle / cosine word width
    localparam int FRAC_W      = 10;   // fractional bits, scale 1024
    localparam int TIMEOUT_CYC = 255;  // core-wait watchdog limit

    // Angle constants at FRAC_W = 10
    localparam logic [ANGLE_W-1:0] PI_C     = ANGLE_W'(3217);
    localparam logic [ANGLE_W-1:0] TWO_PI_C = ANGLE_W'(6434);
    localparam logic [ANGLE_W-1:0] PI_2_C   = ANGLE_W'(1608);

    // Reduction runs k = 10 down to 0; 6434<<10 is the largest multiple
    // that still fits under the saturated |angle| maximum.
    localparam logic [3:0] RR_TOP_K = 4'd10;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ABS    = 4'd1,
        REDUCE = 4'd2,
        FOLD1  = 4'd3,
        FOLD2  = 4'd4,
        LAUNCH = 4'd5,
        WAIT   = 4'd6,
        SIGN   = 4'd7,
        DONE   = 4'd8
    } state_t;

    // One conditional-subtract step of the reduction. The compare is done
    // one bit wider than the data so the shifted modulus never wraps.
    function automatic logic [ANGLE_W-1:0] mod_step(
        input logic [ANGLE_W-1:0] a,
        input logic [3:0]         k
    );
        logic [ANGLE_W:0] sub;
        sub = {1'b0, TWO_PI_C} << k;
        if ({1'b0, a} >= sub)
            mod_step = a - sub[ANGLE_W-1:0];
        else
            mod_step = a;
    endfunction

endpackage : cos_pkg
`default_nettype wire

// File: rtl/rr_mod2pi.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mod2pi
//  Description : 11-step shift-subtract reducer. Given a non-negative angle
//                it returns the angle modulo 2*pi in [0, TWO_PI_C). Step k=10
//                is applied on the cycle start is sampled, steps 9..0 on the
//                following ten cycles; done pulses for one cycle afterwards.
//  Ports       : clock, reset (async, active-low)
//                start  - begin reduction of a_in
//                a_in   - non-negative angle (unsigned, ANGLE_W bits)
//                done   - one-cycle pulse, a_out valid from this cycle on
//                a_out  - reduced angle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mod2pi
    import cos_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ANGLE_W-1:0] a_in,
    output logic               done,
    output logic [ANGLE_W-1:0] a_out
);

    logic [ANGLE_W-1:0] acc;
    logic [3:0]         k;
    logic               busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            k    <= 4'd0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc  <= mod_step(a_in, RR_TOP_K);
                k    <= RR_TOP_K - 4'd1;
                busy <= 1'b1;
            end else if (busy) begin
                acc <= mod_step(acc, k);
                if (k == 4'd0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    k <= k - 4'd1;
                end
            end
        end
    end

    assign a_out = acc;

endmodule : rr_mod2pi
`default_nettype wire

// File: rtl/cos_range_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : cos_range_reduce
//  Description : Front end for the Horner/Taylor cosine core. Reduces any
//                signed fixed-point angle into [0, pi/2] using cos symmetry
//                and periodicity, launches the core, and applies the quadrant
//                sign to the core's magnitude result.
//  Ports       : clock, reset (async, active-low)
//                start, angle_in          - request, sampled on rising edge
//                ready_out, cos_out       - result, held until next start
//                error_out                - core watchdog expired
//                core_start, core_angle   - launch to cosine core
//                core_ready, core_cos     - result from cosine core
//  Options     : COS_RR_TIMEOUT_EN - enables the core-wait watchdog; without
//                it WAIT waits indefinitely and error_out is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module cos_range_reduce
    import cos_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [ANGLE_W-1:0] angle_in,
    output logic               ready_out,
    output logic [ANGLE_W-1:0] cos_out,
    output logic               error_out,
    output logic               core_start,
    output logic [ANGLE_W-1:0] core_angle,
    input  logic               core_ready,
    input  logic [ANGLE_W-1:0] core_cos
);

    state_t             state;
    logic               start_q;
    logic               core_ready_q;
    logic [ANGLE_W-1:0] angle_q;
    logic [ANGLE_W-1:0] a_val;
    logic [ANGLE_W-1:0] cos_mag;
    logic               neg;
    logic               rr_start;
    logic               rr_done;
    logic [ANGLE_W-1:0] rr_out;
    logic [ANGLE_W-1:0] abs_val;
    logic               accept;
    logic               core_rise;

    // Starts are only honoured between operations.
    assign accept    = start && !start_q && (state == IDLE || state == DONE);
    // A level left high by a previous operation must not complete this one.
    assign core_rise = core_ready && !core_ready_q;

    // |angle|; the most negative code has no positive twin and saturates.
    always_comb begin
        abs_val = angle_q;
        if (angle_q == {1'b1, {(ANGLE_W-1){1'b0}}})
            abs_val = {1'b0, {(ANGLE_W-1){1'b1}}};
        else if (angle_q[ANGLE_W-1])
            abs_val = ANGLE_W'(0) - angle_q;
    end

    rr_mod2pi u_rr_mod2pi (
        .clock (clock),
        .reset (reset),
        .start (rr_start),
        .a_in  (a_val),
        .done  (rr_done),
        .a_out (rr_out)
    );

`ifdef COS_RR_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WCNT_W-1:0] wait_cnt;
`else
    assign error_out = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            core_ready_q <= 1'b0;
            angle_q      <= '0;
            a_val        <= '0;
            cos_mag      <= '0;
            neg          <= 1'b0;
            rr_start     <= 1'b0;
            ready_out    <= 1'b0;
            cos_out      <= '0;
            core_start   <= 1'b0;
            core_angle   <= '0;
`ifdef COS_RR_TIMEOUT_EN
            error_out    <= 1'b0;
            wait_cnt     <= '0;
`endif
        end else begin
            start_q      <= start;
            core_ready_q <= core_ready;
            rr_start     <= 1'b0;

            if (accept) begin
                angle_q   <= angle_in;
                ready_out <= 1'b0;
`ifdef COS_RR_TIMEOUT_EN
                error_out <= 1'b0;
`endif
                state     <= ABS;
            end else begin
                case (state)
                    IDLE: ;
                    ABS: begin
                        a_val    <= abs_val;
                        rr_start <= 1'b1;
                        state    <= REDUCE;
                    end
                    REDUCE: begin
                        if (rr_done) begin
                            a_val <= rr_out;
                            state <= FOLD1;
                        end
                    end
                    FOLD1: begin
                        // Even symmetry: cos(a) = cos(2*pi - a)
                        if (a_val >= PI_C)
                            a_val <= TWO_PI_C - a_val;
                        state <= FOLD2;
                    end
                    FOLD2: begin
                        // cos(a) = -cos(pi - a); result lands directly on
                        // the core port so core_start is high during LAUNCH.
                        if (a_val > PI_2_C) begin
                            core_angle <= PI_C - a_val;
                            neg        <= 1'b1;
                        end else begin
                            core_angle <= a_val;
                            neg        <= 1'b0;
                        end
                        core_start <= 1'b1;
                        state      <= LAUNCH;
                    end
                    LAUNCH: begin
                        core_start <= 1'b0;
`ifdef COS_RR_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                        state      <= WAIT;
                    end
                    WAIT: begin
                        if (core_rise) begin
                            cos_mag <= core_cos;
                            state   <= SIGN;
                        end
`ifdef COS_RR_TIMEOUT_EN
                        else if (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1)) begin
                            error_out <= 1'b1;
                            cos_out   <= '0;
                            state     <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
`endif
                    end
                    SIGN: begin
                        cos_out <= neg ? (ANGLE_W'(0) - cos_mag) : cos_mag;
                        state   <= DONE;
                    end
                    DONE: begin
                        ready_out <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule : cos_range_reduce
`default_nettype wire

// File: tb/tb_cos_range_reduce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cos_range_reduce
//  Description : Self-checking bench for cos_range_reduce. Contains a
//                behavioural cosine-core model (real cos, rounded to 1/1024)
//                and an arithmetic reference for the angle reduction.
//                Define COS_RR_TIMEOUT_EN to also exercise the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cos_range_reduce;
    import cos_pkg::*;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [ANGLE_W-1:0] angle_in = '0;
    logic               ready_out;
    logic [ANGLE_W-1:0] cos_out;
    logic               error_out;
    logic               core_start;
    logic [ANGLE_W-1:0] core_angle;
    logic               core_ready = 1'b0;
    logic [ANGLE_W-1:0] core_cos = '0;

    int n_checks = 0;
    int n_fail   = 0;

    cos_range_reduce dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .angle_in   (angle_in),
        .ready_out  (ready_out),
        .cos_out    (cos_out),
        .error_out  (error_out),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_ready (core_ready),
        .core_cos   (core_cos)
    );

    always #5 clock = ~clock;

    // ---------------- reference functions ----------------
    function automatic int cos_core(input int ca);
        real r;
        r = $cos(real'(ca) / 1024.0) * 1024.0;
        return $rtoi(r + 0.5);
    endfunction

    function automatic void ref_reduce(input logic [ANGLE_W-1:0] ang,
                                       output int ca, output bit ng);
        longint a;
        a = longint'($signed(ang));
        if (a < 0) a = -a;
        if (a > 8388607) a = 8388607;
        a = a % 6434;
        if (a >= 3217) a = 6434 - a;
        ng = 1'b0;
        if (a > 1608) begin
            a  = 3217 - a;
            ng = 1'b1;
        end
        ca = int'(a);
    endfunction

    // ---------------- cosine core model ----------------
    int                 core_lat  = 4;
    bit                 core_mute = 1'b0;  // never answer
    bit                 core_hold = 1'b0;  // keep ready high, dip just before answer
    int                 mcnt;
    logic               mpend;
    logic [ANGLE_W-1:0] lat_angle;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            core_ready <= 1'b0;
            mpend      <= 1'b0;
            mcnt       <= 0;
        end else if (core_start) begin
            if (!core_hold) core_ready <= 1'b0;
            mpend     <= 1'b1;
            mcnt      <= core_lat;
            lat_angle <= core_angle;
        end else if (mpend && !core_mute) begin
            if (mcnt <= 1) begin
                core_ready <= 1'b1;
                core_cos   <= ANGLE_W'(cos_core(int'(lat_angle)));
                mpend      <= 1'b0;
            end else begin
                if (mcnt == 2) core_ready <= 1'b0;
                mcnt <= mcnt - 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},      longint'(ready_out),  0);
        check({tag, "_cos"},        longint'(cos_out),    0);
        check({tag, "_err"},        longint'(error_out),  0);
        check({tag, "_core_start"}, longint'(core_start), 0);
        check({tag, "_core_angle"}, longint'(core_angle), 0);
    endtask

    // Full operation with latency checks. Start is sampled at edge k.
    task automatic run_op(input string tag, input logic [ANGLE_W-1:0] ang,
                          input int exp_ca, input logic [ANGLE_W-1:0] exp_cos);
        bit seen_low;
        bit low_ok;
        int guard;
        start    = 1'b1;
        angle_in = ang;
        tick();                                  // edge k
        start    = 1'b0;
        angle_in = ANGLE_W'($urandom);           // must have been latched
        check({tag, "_ready_clr"}, longint'(ready_out), 0);
        check({tag, "_err_clr"},   longint'(error_out), 0);
        repeat (14) tick();                      // edge k+14
        check({tag, "_cs_early"}, longint'(core_start), 0);
        tick();                                  // edge k+15
        check({tag, "_cs_high"},   longint'(core_start), 1);
        check({tag, "_core_angle"}, longint'(core_angle), longint'(exp_ca));
        tick();                                  // edge k+16
        check({tag, "_cs_low"}, longint'(core_start), 0);
        seen_low = 1'b0;
        low_ok   = 1'b1;
        for (guard = 0; guard < 200; guard++) begin
            if (!core_ready) seen_low = 1'b1;
            else if (seen_low) break;            // visible after edge m-1
            if (ready_out) low_ok = 1'b0;
            tick();
        end
        check({tag, "_core_rise_seen"}, longint'(guard < 200), 1);
        if (guard >= 200) return;
        check({tag, "_ready_waits"}, longint'(low_ok), 1);
        repeat (3) tick();                       // edge m+2
        check({tag, "_ready"}, longint'(ready_out), 1);
        check({tag, "_cos"},   longint'(cos_out),   longint'(exp_cos));
        check({tag, "_err"},   longint'(error_out), 0);
        repeat (2) tick();
        check({tag, "_cos_hold"},   longint'(cos_out),   longint'(exp_cos));
        check({tag, "_ready_hold"}, longint'(ready_out), 1);
    endtask

    typedef struct {
        logic [ANGLE_W-1:0] ang;
        int                 exp_ca;
        logic [ANGLE_W-1:0] exp_cos;
    } vec_t;

    vec_t vecs[7];

    // ---------------- main sequence ----------------
    initial begin
        int                 ca;
        bit                 ng;
        int                 m;
        int                 pulses;
        logic [ANGLE_W-1:0] a;
        logic [ANGLE_W-1:0] e;

        vecs[0] = '{24'd512,     512,  24'd899};
        vecs[1] = '{24'd3072,    145,  24'hFFFC0A};
        vecs[2] = '{24'hFFE400,  734,  24'd772};      // -7.0
        vecs[3] = '{24'd6434,    0,    24'd1024};
        vecs[4] = '{24'h800000,  1329, 24'd276};      // saturating |angle|
        vecs[5] = '{24'd1608,    1608, 24'd0};        // exactly pi/2, no fold
        vecs[6] = '{24'd3217,    0,    24'hFFFC00};   // pi -> -1.0

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Table-driven directed vectors
        for (int i = 0; i < 7; i++) begin
            core_lat = 1 + (i % 4);
            run_op($sformatf("vec%0d", i), vecs[i].ang, vecs[i].exp_ca, vecs[i].exp_cos);
        end

        // Randomized against reference model
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) begin
                a = ANGLE_W'($urandom_range(0, 20000));
                if ($urandom_range(0, 1) == 1) a = ANGLE_W'(0) - a;
            end else begin
                a = ANGLE_W'($urandom);
            end
            ref_reduce(a, ca, ng);
            m = cos_core(ca);
            e = ng ? ANGLE_W'(-m) : ANGLE_W'(m);
            core_lat = int'($urandom_range(1, 12));
            run_op($sformatf("rnd%0d", i), a, ca, e);
        end

        // Stale core_ready level must not complete the next operation
        core_hold = 1'b1;
        core_lat  = 6;
        run_op("stale_ready", 24'd3072, 145, 24'hFFFC0A);
        core_hold = 1'b0;

        // Start held for 3 cycles, plus extra pulses while busy: one launch
        core_lat = 20;
        start    = 1'b1;
        angle_in = 24'd512;
        tick(); tick(); tick();
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 8 || i == 16) begin
                start    = 1'b1;
                angle_in = 24'd3072;
            end else begin
                start = 1'b0;
            end
            tick();
            if (core_start) begin
                pulses++;
                check("held_core_angle", longint'(core_angle), 512);
            end
        end
        check("held_one_pulse", longint'(pulses), 1);
        check("held_ready",     longint'(ready_out), 1);
        check("held_cos",       longint'(cos_out), 899);

        // Asynchronous reset in the middle of REDUCE
        core_lat = 3;
        start    = 1'b1;
        angle_in = 24'd3072;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        reset = 1'b1;
        tick();
        run_op("after_reset", 24'hFFE400, 734, 24'd772);

`ifdef COS_RR_TIMEOUT_EN
        // Core never answers: watchdog completes the operation with error
        core_mute = 1'b1;
        start     = 1'b1;
        angle_in  = 24'd512;
        tick();
        start = 1'b0;
        m = 0;
        while (!ready_out && m < 400) begin
            tick();
            m++;
        end
        check("to_ready",  longint'(ready_out), 1);
        check("to_err",    longint'(error_out), 1);
        check("to_cos",    longint'(cos_out),   0);
        check("to_window", longint'(m >= 271 && m <= 274), 1);
        core_mute = 1'b0;
        core_lat  = 2;
        run_op("after_timeout", 24'd512, 512, 24'd899);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule : tb_cos_range_reduce
`default_nettype wire

// File: doc/cos_range_reduce.md
Name: cos_range_reduce

Overview:
Front-end stage for the Horner/Taylor cosine core (taylor_horner_rtl). It accepts an arbitrary signed fixed-point angle and reduces it to [0, pi/2] using cos even-symmetry and periodicity. It launches the core over the core's start/ready handshake, then applies the quadrant sign to the core's magnitude result. The system therefore computes cos over the full 24-bit angle range while the core only ever sees its accurate interval.

Parameters:
ANGLE_W, 24, width of angle and cosine words
FRAC_W, 10, fractional bits (fixed-point scale 1024)
TIMEOUT_CYC, 255, core-wait watchdog limit in cycles (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  request; an operation begins on a sampled rising edge
angle_in  in  ANGLE_W  signed two's-complement angle, radians, FRAC_W fractional bits
ready_out  out  1  result valid; held high until the next accepted start
cos_out  out  ANGLE_W  signed cosine, FRAC_W fractional bits
error_out  out  1  core watchdog expired (tied 0 without the optional feature)
core_start  out  1  start to taylor_horner_rtl
core_angle  out  ANGLE_W  reduced angle in [0, PI_2_C], unsigned
core_ready  in  1  ready_out of taylor_horner_rtl
core_cos  in  ANGLE_W  cos_out of taylor_horner_rtl, non-negative magnitude

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0 (ready_out, cos_out, error_out, core_start, core_angle). start_q=0, core_ready_q=0.
- Constants (FRAC_W=10): PI_C=3217, TWO_PI_C=6434, PI_2_C=1608.
- Start edge: start=1 and start_q=0, sampled in IDLE or DONE. Starts are ignored in every other state. A start held high does not retrigger.
- On acceptance: latch angle_in, clear ready_out and error_out.
- ABS (1 cycle): a=|angle|. The value -2^(ANGLE_W-1) saturates to 2^(ANGLE_W-1)-1.
- REDUCE (11 cycles, k=10 down to 0): if a >= TWO_PI_C<<k then a -= TWO_PI_C<<k. Result: a in [0, TWO_PI_C). Use ANGLE_W+1-bit compare; no overflow.
- FOLD1 (1 cycle): if a >= PI_C then a = TWO_PI_C - a.
- FOLD2 (1 cycle): if a > PI_2_C then a = PI_C - a and neg=1; else neg=0.
- LAUNCH: core_angle=a; core_start=1 for exactly one cycle.
- Pre-core latency: start sampled at edge k gives core_start high from edge k+15 to edge k+16.
- WAIT: hold core_angle; wait for a core_ready rising edge (core_ready=1, core_ready_q=0). A core_ready level left high from a prior operation is ignored.
- SIGN (1 cycle): cos_out = neg ? -core_cos : core_cos.
- DONE: ready_out=1. Timing: core_ready rise sampled at edge m gives cos_out and ready_out valid at edge m+2. Both remain stable until the next accepted start.
- Reset mid-operation: immediate return to IDLE; core_start deasserts asynchronously. Any result in flight is lost.

Optional Feature:
COS_RR_TIMEOUT_EN
- Defined: an 8-bit+ counter runs in WAIT. After TIMEOUT_CYC cycles without a core_ready rise, go to DONE with error_out=1, cos_out=0, ready_out=1. error_out clears on the next accepted start.
- Undefined: no counter; WAIT waits indefinitely; error_out constant 0.

Decomposition:
- Package cos_pkg: ANGLE_W, FRAC_W, PI_C, TWO_PI_C, PI_2_C, and the state enum (IDLE, ABS, REDUCE, FOLD1, FOLD2, LAUNCH, WAIT, SIGN, DONE).
- One sub-module, rr_mod2pi: the 11-step shift-subtract reducer with start/done. The FSM, folding, sign and handshake stay in cos_range_reduce.

Test Plan:
- angle_in=512 (0.5); bench core model returns 899 -> core_angle=512 at edge k+15; cos_out=899; error_out=0.
- angle_in=3072 (3.0) -> core_angle=145, neg=1; model returns 1014 -> cos_out=-1014 (0xFFFC0A).
- angle_in=-7168 (-7.0) -> core_angle=734, neg=0. angle_in=6434 -> core_angle=0.
- angle_in=0x800000 -> saturates to 8388607, mod 6434 gives 5105, FOLD1 gives 1329 -> core_angle=1329, neg=0.
- start held high for 3 cycles -> exactly one core_start pulse. reset=0 asserted during REDUCE -> all outputs 0 immediately; the next start completes normally.
- COS_RR_TIMEOUT_EN defined, model never raises core_ready -> ready_out=1, error_out=1, cos_out=0 after 255 WAIT cycles.
